// File: rtl/map9_ctrl_if.sv
// -----------------------------------------------------------------------------
// map9_ctrl_if -- host-side command/result bundle for map9_ctrl.
//
// Signals:
//   cmd_valid / cmd_ready / cmd_n   command channel (host -> controller)
//   res_valid / res_ready           result channel (controller -> host)
//   res_data / res_err              captured engine result and timeout flag
//
// Modports:
//   master  the host: drives the command and consumes the result
//   slave   the controller (map9_ctrl)
// -----------------------------------------------------------------------------
interface map9_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_n;
    logic       res_valid;
    logic       res_ready;
    logic [8:0] res_data;
    logic       res_err;

    modport master (
        output cmd_valid, cmd_n, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_n, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/map9_ctrl.sv
// -----------------------------------------------------------------------------
// map9_ctrl -- sequences one map9 engine computation per accepted command.
//
// A command (cmd_n) is accepted in IDLE, registered onto N, and the engine is
// started by holding `start` high for START_HOLD cycles. The controller then
// waits in RUN for a rising edge of the engine's sticky `done` level, captures
// `dp`, and presents it on the result channel until the host takes it.
//
// Parameters:
//   START_HOLD  cycles `start` is held per command (1..7)
//   TIMEOUT     RUN watchdog limit in cycles (1..1023)
//
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   io            map9_ctrl_if.slave: command and result channels
//   N, start      operand and start request to the engine
//   dp, done      engine result and completion level
//   busy          high whenever the FSM is not in IDLE
//
// Build option:
//   MAP9_CTRL_TIMEOUT_EN  when defined, a 10-bit watchdog aborts RUN after
//                         TIMEOUT cycles with res_err=1 and res_data=9'h1FF.
//                         When undefined, RUN waits indefinitely.
// -----------------------------------------------------------------------------
module map9_ctrl #(
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clock,
    input  logic       reset,
    map9_ctrl_if.slave io,
    output logic [8:0] N,
    output logic       start,
    input  logic [8:0] dp,
    input  logic       done,
    output logic       busy
);

    if (START_HOLD < 1 || START_HOLD > 7) begin : g_bad_start_hold
        $error("map9_ctrl: START_HOLD must be in 1..7");
    end
    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("map9_ctrl: TIMEOUT must be in 1..1023");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        HOLD
    } state_t;

    localparam logic [2:0] HOLD_LAST = 3'(START_HOLD - 1);

    state_t     state_q, state_d;
    logic [8:0] n_q, n_d;
    logic [2:0] hold_cnt_q, hold_cnt_d;
    logic       done_q, done_d;
    logic [8:0] res_data_q, res_data_d;
    logic       rise;

`ifdef MAP9_CTRL_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    logic [9:0] to_cnt_q, to_cnt_d;
    logic       res_err_q, res_err_d;
`endif

    // Only a fresh edge of the sticky done level counts; a level left over
    // from the previous run is ignored.
    assign rise = done & ~done_q;

    // NOTE: every variable assigned below gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = done;
        res_data_d = res_data_q;
`ifdef MAP9_CTRL_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        res_err_d  = res_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (io.cmd_valid) begin
                    n_d        = io.cmd_n;
                    hold_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = RUN;
`ifdef MAP9_CTRL_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q + 3'd1;
                end
            end
            RUN: begin
                // A rise on the last watchdog cycle still counts as success.
                if (rise) begin
                    res_data_d = dp;
`ifdef MAP9_CTRL_TIMEOUT_EN
                    res_err_d  = 1'b0;
`endif
                    state_d    = HOLD;
                end
`ifdef MAP9_CTRL_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    res_data_d = 9'h1FF;
                    res_err_d  = 1'b1;
                    state_d    = HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + 10'd1;
                end
`endif
            end
            HOLD: begin
                // Any done edge seen here is dropped; the next capture needs
                // a new command.
                if (io.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of block order.
    // The result register is reset too, so no stale data is visible after an
    // abandoned command.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
            res_data_q <= '0;
`ifdef MAP9_CTRL_TIMEOUT_EN
            to_cnt_q   <= '0;
            res_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
            res_data_q <= res_data_d;
`ifdef MAP9_CTRL_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            res_err_q  <= res_err_d;
`endif
        end
    end

    assign io.cmd_ready = (state_q == IDLE);
    assign io.res_valid = (state_q == HOLD);
    assign io.res_data  = res_data_q;
`ifdef MAP9_CTRL_TIMEOUT_EN
    assign io.res_err   = res_err_q;
`else
    assign io.res_err   = 1'b0;
`endif
    assign start        = (state_q == START);
    assign busy         = (state_q != IDLE);
    assign N            = n_q;

endmodule

// File: tb/tb_map9_ctrl.sv
// -----------------------------------------------------------------------------
// tb_map9_ctrl -- directed self-checking bench for map9_ctrl.
//
// dut  : START_HOLD=2, TIMEOUT=16 -- basic run, backpressure, stale done,
//        done edge while leaving HOLD, reset mid-RUN, watchdog.
// dut1 : START_HOLD=1, TIMEOUT=1023 -- back-to-back commands.
// The engine is modelled by driving done/dp directly from the stimulus.
// -----------------------------------------------------------------------------
module tb_map9_ctrl;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    map9_ctrl_if bus ();
    map9_ctrl_if bus1 ();

    logic [8:0] n0, dp0, n1, dp1;
    logic       start0, done0, busy0;
    logic       start1, done1, busy1;

    map9_ctrl #(.START_HOLD(2), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus),
        .N     (n0),
        .start (start0),
        .dp    (dp0),
        .done  (done0),
        .busy  (busy0)
    );

    map9_ctrl #(.START_HOLD(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .io    (bus1),
        .N     (n1),
        .start (start1),
        .dp    (dp1),
        .done  (done1),
        .busy  (busy1)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int starts1 = 0;

    // Counts cycles in which dut1 drives start, i.e. start pulses when
    // START_HOLD=1.
    always @(posedge clock) begin
        if (start1) starts1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic [8:0] v1 [3];
    logic [8:0] r1 [3];

    initial begin
        v1[0] = 9'h011; v1[1] = 9'h122; v1[2] = 9'h0F3;
        r1[0] = 9'h1A0; r1[1] = 9'h05B; r1[2] = 9'h1EE;

        reset = 1'b1;
        bus.cmd_valid  = 1'b0; bus.cmd_n  = '0; bus.res_ready  = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_n = '0; bus1.res_ready = 1'b0;
        done0 = 1'b0; dp0 = '0; done1 = 1'b0; dp1 = '0;

        // ---- reset state ----
        tick(2);
        check("rst cmd_ready", bus.cmd_ready, 1);
        check("rst start",     start0, 0);
        check("rst res_valid", bus.res_valid, 0);
        check("rst busy",      busy0, 0);
        check("rst N",         n0, 0);
        check("rst res_data",  bus.res_data, 0);
        check("rst res_err",   bus.res_err, 0);
        reset = 1'b0;
        tick(1);

        // ---- basic run: 0x0A5, done after 40 RUN cycles with dp=0x133 ----
        bus.cmd_valid = 1'b1; bus.cmd_n = 9'h0A5;
        tick(1);
        bus.cmd_valid = 1'b0;
        check("basic start c1",   start0, 1);
        check("basic N",          n0, 9'h0A5);
        check("basic cmd_ready",  bus.cmd_ready, 0);
        check("basic busy",       busy0, 1);
        tick(1);
        check("basic start c2",   start0, 1);
        tick(1);
        check("basic start off",  start0, 0);
        tick(39);
        check("basic no early res", bus.res_valid, 0);
        done0 = 1'b1; dp0 = 9'h133;
        tick(1);
        check("basic res_valid",  bus.res_valid, 1);
        check("basic res_data",   bus.res_data, 9'h133);
        check("basic res_err",    bus.res_err, 0);

        // ---- backpressure: 20 cycles of res_ready=0, second command ignored ----
        bus.cmd_valid = 1'b1; bus.cmd_n = 9'h055;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("bp res_data",  bus.res_data, 9'h133);
            check("bp cmd_ready", bus.cmd_ready, 0);
            check("bp res_valid", bus.res_valid, 1);
        end
        bus.cmd_valid = 1'b0; bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
        check("bp cmd_ready after", bus.cmd_ready, 1);
        check("bp res_valid after", bus.res_valid, 0);
        check("bp N unchanged",     n0, 9'h0A5);

        // ---- stale done: high through START and 3 RUN cycles ----
        bus.cmd_valid = 1'b1; bus.cmd_n = 9'h1C3;
        tick(1);
        bus.cmd_valid = 1'b0;
        check("stale N", n0, 9'h1C3);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stale no res hi", bus.res_valid, 0);
        end
        done0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("stale no res lo", bus.res_valid, 0);
        end
        done0 = 1'b1; dp0 = 9'h07E;
        tick(1);
        check("stale res_valid", bus.res_valid, 1);
        check("stale res_data",  bus.res_data, 9'h07E);

        // ---- done edge in the cycle HOLD is left is ignored ----
        done0 = 1'b0;
        tick(1);
        check("hold still valid", bus.res_valid, 1);
        done0 = 1'b1; dp0 = 9'h111; bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
        check("hold exit res_valid", bus.res_valid, 0);
        check("hold exit res_data",  bus.res_data, 9'h07E);
        check("hold exit busy",      busy0, 0);

        // ---- reset mid-RUN, with competing inputs in the reset cycle ----
        done0 = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_n = 9'h0F0;
        tick(1);
        bus.cmd_valid = 1'b0;
        tick(5);
        check("midrst busy before", busy0, 1);
        reset = 1'b1; done0 = 1'b1; dp0 = 9'h0AA; bus.cmd_valid = 1'b1; bus.cmd_n = 9'h1BB;
        tick(1);
        check("midrst cmd_ready", bus.cmd_ready, 1);
        check("midrst start",     start0, 0);
        check("midrst res_valid", bus.res_valid, 0);
        check("midrst N",         n0, 0);
        check("midrst busy",      busy0, 0);
        check("midrst res_data",  bus.res_data, 0);
        reset = 1'b0; bus.cmd_valid = 1'b0;
        tick(3);
        check("midrst no result", bus.res_valid, 0);
        check("midrst idle",      busy0, 0);

        // ---- watchdog: done stays high (no rise) through RUN ----
        bus.cmd_valid = 1'b1; bus.cmd_n = 9'h02A;
        tick(1);
        bus.cmd_valid = 1'b0;
        tick(2);
        check("to start off", start0, 0);
`ifdef MAP9_CTRL_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("to no early res", bus.res_valid, 0);
        end
        tick(1);
        check("to res_valid", bus.res_valid, 1);
        check("to res_err",   bus.res_err, 1);
        check("to res_data",  bus.res_data, 9'h1FF);
        bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
        check("to cmd_ready", bus.cmd_ready, 1);

        // rise on the 16th RUN cycle beats the watchdog
        done0 = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_n = 9'h033;
        tick(1);
        bus.cmd_valid = 1'b0;
        tick(2);
        tick(15);
        check("to edge no res", bus.res_valid, 0);
        done0 = 1'b1; dp0 = 9'h099;
        tick(1);
        check("to edge res_valid", bus.res_valid, 1);
        check("to edge res_err",   bus.res_err, 0);
        check("to edge res_data",  bus.res_data, 9'h099);
        bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
`else
        tick(40);
        check("no-to res_valid", bus.res_valid, 0);
        check("no-to busy",      busy0, 1);
        done0 = 1'b0;
        tick(1);
        done0 = 1'b1; dp0 = 9'h0C4;
        tick(1);
        check("no-to res_valid late", bus.res_valid, 1);
        check("no-to res_data",       bus.res_data, 9'h0C4);
        check("no-to res_err",        bus.res_err, 0);
        bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
`endif
        check("to back idle", busy0, 0);

        // ---- back-to-back on dut1 (START_HOLD=1), res_ready held high ----
        bus1.res_ready = 1'b1;
        bus1.cmd_valid = 1'b1; bus1.cmd_n = v1[0];
        for (int k = 0; k < 3; k++) begin
            check("b2b cmd_ready", bus1.cmd_ready, 1);
            tick(1);
            check("b2b start", start1, 1);
            check("b2b N",     n1, v1[k]);
            tick(1);
            check("b2b start off", start1, 0);
            done1 = 1'b1; dp1 = r1[k];
            if (k < 2) bus1.cmd_n = v1[k + 1];
            else       bus1.cmd_valid = 1'b0;
            tick(1);
            check("b2b res_valid", bus1.res_valid, 1);
            check("b2b res_data",  bus1.res_data, r1[k]);
            done1 = 1'b0;
            tick(1);
        end
        tick(2);
        check("b2b start pulses", starts1, 3);
        check("b2b idle", busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/map9_ctrl.md
MAP9_CTRL -- requirements
Module: map9_ctrl

Interface
REQ-001 Parameter START_HOLD, default 2: cycles `start` is driven high per command (legal range 1..7).
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles in RUN before abort (legal range 1..1023).
REQ-003 Port `clock`, in, 1: single clock; all logic is rising-edge.
REQ-004 Port `reset`, in, 1: synchronous, active-high reset.
REQ-005 Port `cmd_valid`, in, 1: command word present.
REQ-006 Port `cmd_ready`, out, 1: command accepted on a cycle where cmd_valid & cmd_ready.
REQ-007 Port `cmd_n`, in, 9: operand to compute.
REQ-008 Port `N`, out, 9: operand to map9 engine.
REQ-009 Port `start`, out, 1: start request to the engine.
REQ-010 Port `dp`, in, 9: engine result.
REQ-011 Port `done`, in, 1: engine completion level; sticky until the engine's next start.
REQ-012 Port `res_valid`, out, 1: result held.
REQ-013 Port `res_ready`, in, 1: result consumed on a cycle where res_valid & res_ready.
REQ-014 Port `res_data`, out, 9: captured dp.
REQ-015 Port `res_err`, out, 1: result aborted by timeout.
REQ-016 Port `busy`, out, 1: FSM not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, START, RUN, HOLD.
- IDLE: cmd_ready=1.
- IDLE→START on handshake.
REQ-018 On handshake, cmd_n SHALL be registered to N.
- N SHALL stay constant until the next handshake.
REQ-019 In START, start SHALL be 1 for exactly START_HOLD consecutive cycles, then START→RUN.
- start SHALL be 0 in every other state.
REQ-020 A registered done_q SHALL track done; rise = done & ~done_q.
REQ-021 In RUN, on rise:
- dp SHALL be captured into res_data, res_err=0, RUN→HOLD.
- Stale done high on RUN entry SHALL be ignored; only a rise counts.
REQ-022 In HOLD, res_valid=1; res_data and res_err SHALL be stable.
- HOLD→IDLE on res_ready.
- cmd_ready SHALL be 0 in HOLD.
REQ-023 cmd_ready SHALL be 0 in START, RUN and HOLD.
- cmd_valid outside IDLE SHALL be ignored, not queued.
REQ-024 Handshake-to-first-start latency SHALL be 1 cycle.
- Rise-to-res_valid latency SHALL be 1 cycle.
- res_ready-to-cmd_ready latency SHALL be 1 cycle.
REQ-025 If done rises in the same cycle HOLD is exited, it SHALL be ignored.

Reset
REQ-026 On reset, outputs SHALL take these values next edge:
- FSM=IDLE, N=0, start=0.
- res_valid=0, res_data=0, res_err=0, busy=0.
- cmd_ready=1, done_q=0, timers=0.
REQ-027 Reset mid-operation (any state) SHALL abandon the command with no result emitted.
REQ-028 reset SHALL dominate all other inputs in the same cycle.

Configuration
REQ-029 Macro MAP9_CTRL_TIMEOUT_EN SHALL enable the RUN watchdog (10-bit counter, cleared on RUN entry).
- Defined: after TIMEOUT cycles in RUN without rise, go RUN→HOLD with res_err=1 and res_data=9'h1FF.
- Defined: a rise on the TIMEOUT-th cycle SHALL win over timeout.
- Undefined: no counter is built, res_err is tied 0, and RUN waits indefinitely.

Verification
REQ-030 Basic run: reset, then cmd_n=9'h0A5; engine model raises done after 40 cycles with dp=9'h133.
- Expect start high 2 cycles, N=9'h0A5, res_valid and res_data=9'h133 one cycle after the rise, res_err=0.
REQ-031 Backpressure: res_ready=0 for 20 cycles.
- Expect res_data stable, cmd_ready=0, and a second cmd_valid ignored.
- After res_ready=1, expect cmd_ready=1 next cycle.
REQ-032 Stale done: done held high from the prior run through START and for the first 3 RUN cycles, then dropped, then raised after 10 cycles.
- Expect exactly one capture, at the new rise.
REQ-033 Reset mid-RUN: assert reset for 1 cycle during RUN.
- Expect IDLE, start=0, res_valid=0, N=0, and no result emitted.
REQ-034 Timeout (MAP9_CTRL_TIMEOUT_EN, TIMEOUT=16): done never rises.
- Expect res_valid at RUN cycle 16 with res_err=1 and res_data=9'h1FF.
- Expect no timeout when the macro is undefined.
REQ-035 Back-to-back commands with res_ready=1 and START_HOLD=1.
- Expect one start pulse per command and results delivered in order.
